// File: rtl/wisard_sched_pkg.sv
// Shared FSM encoding and default sizing for the WiSARD sample scheduler.
// States are published both as an enum and as plain logic constants.
package wisard_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        SEND      = 3'd3,
        GAP       = 3'd4,
        WAIT_PRED = 3'd5,
        RESP      = 3'd6
    } sched_state_e;

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_FETCH     = FETCH;
    localparam logic [2:0] ST_LOAD      = LOAD;
    localparam logic [2:0] ST_SEND      = SEND;
    localparam logic [2:0] ST_GAP       = GAP;
    localparam logic [2:0] ST_WAIT_PRED = WAIT_PRED;
    localparam logic [2:0] ST_RESP      = RESP;

    localparam int DEF_N_REQ           = 2;
    localparam int DEF_REQ_ID_W        = 1;
    localparam int DEF_CLASS_WIDTH     = 1;
    localparam int DEF_TUPLE_WIDTH     = 8;
    localparam int DEF_BITCNT_WIDTH    = 3;
    localparam int DEF_NUM_POS         = 47;
    localparam int DEF_POS_W           = 6;
    localparam int DEF_SAMPLE_W        = 10;
    localparam int DEF_INTERVAL_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;
    localparam int DEF_TIMEOUT_W       = 13;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/wisard_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer and moves the pointer just past the winner when told to.
module wisard_rr_arbiter #(
    parameter int N_REQ    = 2,
    parameter int REQ_ID_W = 1
) (
    input  logic                clk_125MHz,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_i,
    input  logic                advance_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic [REQ_ID_W-1:0] id_o,
    output logic                any_o
);

    localparam logic [REQ_ID_W-1:0] LAST_ID = REQ_ID_W'(N_REQ - 1);

    logic [REQ_ID_W-1:0] ptr_q;
    logic [REQ_ID_W-1:0] ptr_d;
    logic [REQ_ID_W-1:0] sel;
    logic                found;
    int                  idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            sel = idx[REQ_ID_W-1:0];
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                id_o         = sel;
            end
        end
        any_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (id_o == LAST_ID) ? '0 : id_o + 1'b1;
        end
    end

    always_ff @(posedge clk_125MHz or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wisard_sample_scheduler.sv
// Shares one WiSARD core among several requesters: arbitrates, streams each
// tuple of the granted sample LSB-first, then returns the core's prediction.
module wisard_sample_scheduler
    import wisard_sched_pkg::*;
#(
    parameter int N_REQ           = DEF_N_REQ,
    parameter int REQ_ID_W        = DEF_REQ_ID_W,
    parameter int CLASS_WIDTH     = DEF_CLASS_WIDTH,
    parameter int TUPLE_WIDTH     = DEF_TUPLE_WIDTH,
    parameter int BITCNT_WIDTH    = DEF_BITCNT_WIDTH,
    parameter int NUM_POS         = DEF_NUM_POS,
    parameter int POS_W           = DEF_POS_W,
    parameter int SAMPLE_W        = DEF_SAMPLE_W,
    parameter int INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W       = DEF_TIMEOUT_W
) (
    input  logic                        clk_125MHz,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*SAMPLE_W-1:0]   req_sample_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        mem_rd_en_o,
    output logic [SAMPLE_W+POS_W-1:0]   mem_addr_o,
    input  logic [TUPLE_WIDTH-1:0]      mem_rdata_i,
    output logic                        tuple_bit_o,
    output logic                        tuple_valid_o,
    output logic                        sop_o,
    input  logic                        prediction_valid_i,
    input  logic [CLASS_WIDTH-1:0]      predicted_class_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [REQ_ID_W-1:0]         rsp_req_id_o,
    output logic [CLASS_WIDTH-1:0]      rsp_class_o,
    output logic                        rsp_timeout_o,
    output logic                        busy_o,
    output logic                        err_spurious_o
);

    localparam int GAP_W    = clog2_min1(INTERVAL_CYCLES + 1);
    localparam int GAP_LAST = (INTERVAL_CYCLES > 0) ? INTERVAL_CYCLES - 1 : 0;

    logic [2:0]              state_q, state_d;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic [POS_W-1:0]        tuple_idx_q, tuple_idx_d;
    logic [BITCNT_WIDTH-1:0] bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
    logic [TUPLE_WIDTH-1:0]  shreg_q, shreg_d;
    logic [REQ_ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [CLASS_WIDTH-1:0]  rsp_class_q, rsp_class_d;
    logic                    rsp_tmo_q, rsp_tmo_d;
    logic                    err_q, err_d;

    logic                    grant_en;
    logic [N_REQ-1:0]        arb_grant;
    logic [REQ_ID_W-1:0]     arb_id;
    logic                    arb_any;
    logic                    send;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign grant_en = (state_q == ST_IDLE) && rst_n;

    wisard_rr_arbiter #(
        .N_REQ    (N_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_arb (
        .clk_125MHz (clk_125MHz),
        .rst_n      (rst_n),
        .req_i      (req_valid_i & {N_REQ{grant_en}}),
        .advance_i  (arb_any),
        .grant_o    (arb_grant),
        .id_o       (arb_id),
        .any_o      (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        tuple_idx_d = tuple_idx_q;
        bitcnt_d    = bitcnt_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        shreg_d     = shreg_q;
        rsp_id_d    = rsp_id_q;
        rsp_class_d = rsp_class_q;
        rsp_tmo_d   = rsp_tmo_q;
        err_d       = err_q | (prediction_valid_i && (state_q != ST_WAIT_PRED));
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    sample_d    = req_sample_i[arb_id*SAMPLE_W +: SAMPLE_W];
                    rsp_id_d    = arb_id;
                    tuple_idx_d = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shreg_d  = mem_rdata_i;
                bitcnt_d = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (bitcnt_q == BITCNT_WIDTH'(TUPLE_WIDTH - 1)) begin
                    bitcnt_d = '0;
                    if (tuple_idx_q == POS_W'(NUM_POS - 1)) begin
                        tmo_d   = '0;
                        state_d = ST_WAIT_PRED;
                    end else begin
                        tuple_idx_d = tuple_idx_q + 1'b1;
                        gap_d       = '0;
                        state_d     = (INTERVAL_CYCLES == 0) ? ST_FETCH : ST_GAP;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = ST_FETCH;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_WAIT_PRED: begin
                // A prediction landing on the final timeout cycle still wins.
                if (prediction_valid_i) begin
                    rsp_class_d = predicted_class_i;
                    rsp_tmo_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_class_d = '0;
                    rsp_tmo_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_125MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            tuple_idx_q <= '0;
            bitcnt_q    <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            shreg_q     <= '0;
            rsp_id_q    <= '0;
            rsp_class_q <= '0;
            rsp_tmo_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            tuple_idx_q <= tuple_idx_d;
            bitcnt_q    <= bitcnt_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            shreg_q     <= shreg_d;
            rsp_id_q    <= rsp_id_d;
            rsp_class_q <= rsp_class_d;
            rsp_tmo_q   <= rsp_tmo_d;
            err_q       <= err_d;
        end
    end

    assign send           = (state_q == ST_SEND);
    assign req_ready_o    = arb_grant;
    assign mem_rd_en_o    = (state_q == ST_FETCH);
    assign mem_addr_o     = {sample_q, tuple_idx_q};
    assign tuple_bit_o    = send && shreg_q[bitcnt_q];
    assign tuple_valid_o  = send && (bitcnt_q == '0);
    assign sop_o          = tuple_valid_o && (tuple_idx_q == '0);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_req_id_o   = rsp_id_q;
    assign rsp_class_o    = rsp_class_q;
    assign rsp_timeout_o  = rsp_tmo_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign err_spurious_o = err_q;

endmodule

// File: tb/tb_wisard_sample_scheduler.sv
// Randomized and directed bench for wisard_sample_scheduler; the reference
// model predicts every output cycle from the documented timing formulas.
module tb_wisard_sample_scheduler;

    localparam int N_REQ = 2;
    localparam int SW    = 10;
    localparam int PW    = 6;
    localparam int TW    = 8;
    localparam int NP    = 47;
    localparam int IV    = 16;
    localparam int TO    = 4096;
    localparam int AW    = SW + PW;

    logic clk_125MHz = 1'b0;
    always #4 clk_125MHz = ~clk_125MHz;

    logic              rst_n;
    logic [N_REQ-1:0]  req_valid;
    logic [2*SW-1:0]   req_sample;
    logic [N_REQ-1:0]  req_ready;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [TW-1:0]     mem_rdata;
    logic              tuple_bit, tuple_valid, sop;
    logic              prediction_valid;
    logic [0:0]        predicted_class;
    logic              rsp_valid, rsp_ready;
    logic [0:0]        rsp_req_id, rsp_class;
    logic              rsp_timeout, busy, err_spurious;

    // second instance with no inter-tuple gap
    logic [N_REQ-1:0]  req_valid_z;
    logic [N_REQ-1:0]  req_ready_z;
    logic              mem_rd_en_z;
    logic [AW-1:0]     mem_addr_z;
    logic [TW-1:0]     mem_rdata_z;
    logic              tuple_bit_z, tuple_valid_z, sop_z;
    logic              rsp_valid_z, rsp_timeout_z, busy_z, err_spurious_z;
    logic [0:0]        rsp_req_id_z, rsp_class_z;
    logic              pred_z = 1'b0;
    logic [0:0]        pcls_z = 1'b0;
    logic              rsp_ready_z = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int mem_mode = 0;
    int ref_ptr  = 0;

    wisard_sample_scheduler dut (
        .clk_125MHz(clk_125MHz), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_sample_i(req_sample), .req_ready_o(req_ready),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .tuple_bit_o(tuple_bit), .tuple_valid_o(tuple_valid), .sop_o(sop),
        .prediction_valid_i(prediction_valid), .predicted_class_i(predicted_class),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_req_id_o(rsp_req_id),
        .rsp_class_o(rsp_class), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
        .err_spurious_o(err_spurious)
    );

    wisard_sample_scheduler #(.INTERVAL_CYCLES(0)) dut_z (
        .clk_125MHz(clk_125MHz), .rst_n(rst_n),
        .req_valid_i(req_valid_z), .req_sample_i(req_sample), .req_ready_o(req_ready_z),
        .mem_rd_en_o(mem_rd_en_z), .mem_addr_o(mem_addr_z), .mem_rdata_i(mem_rdata_z),
        .tuple_bit_o(tuple_bit_z), .tuple_valid_o(tuple_valid_z), .sop_o(sop_z),
        .prediction_valid_i(pred_z), .predicted_class_i(pcls_z),
        .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z), .rsp_req_id_o(rsp_req_id_z),
        .rsp_class_o(rsp_class_z), .rsp_timeout_o(rsp_timeout_z), .busy_o(busy_z),
        .err_spurious_o(err_spurious_z)
    );

    function automatic logic [TW-1:0] mem_val(input logic [AW-1:0] a);
        logic [15:0] h;
        if (mem_mode == 0) return TW'(a[PW-1:0]);
        h = a * 16'd40503;
        return h[15:8] ^ a[7:0];
    endfunction

    always @(posedge clk_125MHz) begin
        if (mem_rd_en)   mem_rdata   <= mem_val(mem_addr);
        if (mem_rd_en_z) mem_rdata_z <= mem_val(mem_addr_z);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_125MHz);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_outs", {busy, tuple_valid, tuple_bit, sop, mem_rd_en, rsp_valid,
                           req_ready, mem_addr, err_spurious, rsp_timeout}, 32'd0);
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        ref_ptr   = 0;
        tick();
    endtask

    // One full transaction; pred_delay < 0 means the core never answers.
    task automatic run_txn(input logic [1:0] mask, input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                           input bit keep, input int pred_delay, input logic cls,
                           input int rdy_delay, input logic [1:0] resp_mask);
        int g, i, k, off, per, wo, mism, ntv, nsop, cnt;
        logic [1:0]    oh;
        logic [SW-1:0] s;
        logic [AW-1:0] addr;
        logic [TW-1:0] v;
        logic          exp_rd, exp_send, exp_bit, exp_tv, exp_cls, exp_tmo, id_l;
        logic [5:0]    exp_hold;

        g = -1;
        for (int j = 0; j < N_REQ; j++) begin
            i = (ref_ptr + j) % N_REQ;
            if (g < 0 && mask[i]) g = i;
        end
        oh      = 2'b01 << g;
        id_l    = g[0];
        ref_ptr = (g + 1) % N_REQ;
        s       = (g == 0) ? s0 : s1;
        per     = TW + 2 + IV;
        wo      = 1 + NP * (TW + 2) + (NP - 1) * IV;

        check("idle_busy", busy, 0);
        req_sample = {s1, s0};
        req_valid  = mask;
        #1;
        check("grant", req_ready, oh);

        mism = 0; ntv = 0; nsop = 0;
        for (int c = 1; c < wo; c++) begin
            tick();
            if (c == 1) req_valid = keep ? (mask & ~oh) : 2'b00;
            k        = (c - 1) / per;
            off      = (c - 1) % per;
            addr     = {s, PW'(k)};
            v        = mem_val(addr);
            exp_rd   = (off == 0);
            exp_send = (off >= 2) && (off < 2 + TW);
            exp_bit  = exp_send ? v[off-2] : 1'b0;
            exp_tv   = (off == 2);
            if (mem_rd_en !== exp_rd || (exp_rd && mem_addr !== addr) || tuple_bit !== exp_bit ||
                tuple_valid !== exp_tv || sop !== (exp_tv && k == 0) || busy !== 1'b1 ||
                rsp_valid !== 1'b0 || req_ready !== 2'b00)
                mism++;
            if (tuple_valid === 1'b1) ntv++;
            if (sop === 1'b1) nsop++;
        end
        check("stream", mism, 0);
        check("tuple_cnt", ntv, NP);
        check("sop_cnt", nsop, 1);

        tick();
        check("wait_entry", {busy, tuple_valid, rsp_valid}, 3'b100);

        if (pred_delay < 0) begin
            cnt = 0;
            while (rsp_valid !== 1'b1 && cnt < TO + 100) begin
                tick();
                cnt++;
            end
            check("tmo_latency", cnt, TO);
            exp_cls = 1'b0;
            exp_tmo = 1'b1;
        end else begin
            mism = 0;
            for (int d = 0; d < pred_delay; d++) begin
                if (rsp_valid !== 1'b0) mism++;
                tick();
            end
            check("early_rsp", mism, 0);
            prediction_valid = 1'b1;
            predicted_class  = cls;
            tick();
            prediction_valid = 1'b0;
            exp_cls = cls;
            exp_tmo = 1'b0;
        end
        check("rsp", {rsp_valid, rsp_req_id, rsp_class, rsp_timeout}, {1'b1, id_l, exp_cls, exp_tmo});

        exp_hold  = {1'b1, id_l, exp_cls, exp_tmo, 2'b00};
        req_valid = req_valid | resp_mask;
        #1;
        for (int r = 0; r < rdy_delay; r++) begin
            check("rsp_hold", {rsp_valid, rsp_req_id, rsp_class, rsp_timeout, req_ready}, exp_hold);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = keep ? (mask & ~oh) : 2'b00;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp", {rsp_valid, busy, err_spurious}, 3'b000);
        $display("txn req=%b grant=%0d sample=%0d class=%0d timeout=%0d", mask, g, s, exp_cls, exp_tmo);
    endtask

    initial begin
        #(8 * 90000);
        $display("FAIL watchdog: still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int first, second;
        rst_n = 1'b0; req_valid = 2'b11; req_sample = '0; req_valid_z = '0;
        prediction_valid = 1'b0; predicted_class = '0; rsp_ready = 1'b0;
        tick();
        tick();
        do_reset();
        check("reset_idle", {busy, req_ready, err_spurious}, 0);

        // directed: single requester, sample 5, tuple k holds k
        mem_mode = 0;
        run_txn(2'b01, 10'd5, 10'd0, 1'b0, 10, 1'b1, 0, 2'b00);

        // directed: simultaneous requests right after reset
        do_reset();
        run_txn(2'b11, 10'd7, 10'd9, 1'b1, 5, 1'b1, 0, 2'b00);
        run_txn(2'b10, 10'd7, 10'd9, 1'b0, 5, 1'b0, 0, 2'b00);

        // timeout, and prediction exactly on the timeout cycle
        mem_mode = 1;
        run_txn(2'b01, 10'd300, 10'd1, 1'b0, -1, 1'b1, 0, 2'b00);
        run_txn(2'b11, 10'd12, 10'd1023, 1'b0, TO - 1, 1'b1, 2, 2'b00);

        // rsp_ready low for 20 cycles with a request that vanishes before IDLE
        run_txn(2'b01, 10'd77, 10'd88, 1'b0, 3, 1'b1, 20, 2'b10);
        for (int q = 0; q < 3; q++) begin
            check("no_queue", {busy, req_ready}, 3'b000);
            tick();
        end

        // zero-gap instance
        req_sample  = {10'd0, 10'd5};
        req_valid_z = 2'b01;
        #1;
        check("z_grant", req_ready_z, 2'b01);
        first = -1; second = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) req_valid_z = '0;
            if (tuple_valid_z === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        check("z_first_tv", first, 3);
        check("z_tv_spacing", second - first, 10);

        // randomized transactions
        for (int n = 0; n < 8; n++) begin
            run_txn(2'($urandom_range(1, 3)), 10'($urandom), 10'($urandom), 1'b0,
                    $urandom_range(0, 60), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5), 2'($urandom_range(0, 3)));
        end

        // reset in the middle of SEND, then a stray prediction in IDLE
        mem_mode   = 0;
        req_sample = {10'd0, 10'd3};
        req_valid  = 2'b01;
        #1;
        check("rst_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        repeat (28) tick();
        check("pre_rst_tv", tuple_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {busy, tuple_valid, tuple_bit, sop, mem_rd_en, rsp_valid,
                              req_ready, mem_addr, err_spurious}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("err_clear", err_spurious, 1'b0);
        prediction_valid = 1'b1;
        tick();
        prediction_valid = 1'b0;
        check("err_spurious", err_spurious, 1'b1);
        for (int q = 0; q < 5; q++) begin
            check("no_rsp_after_rst", {rsp_valid, busy}, 2'b00);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
